trivium_wide_keystream: RTL

//  Parametrised Trivium keystream generator; produces W keystream bits per clock (W rounds unrolled).

---
 rtl/trivium_pkg.sv | 37 +++
 rtl/trivium_step.sv | 39 +++
 rtl/trivium_wide_keystream.sv | 97 +++++++++
 3 files changed

// File: rtl/trivium_pkg.sv
// Shared constants, FSM encoding and the key/IV load-vector helper for the Trivium keystream core.
// State bit s_i (1-based, as in the cipher description) lives at vector index i-1.
package trivium_pkg;

  localparam int STATE_W         = 288;
  localparam int KEY_W           = 80;
  localparam int INIT_ROUNDS_DEF = 1152;

  localparam int TAP_66  = 66;
  localparam int TAP_93  = 93;
  localparam int TAP_91  = 91;
  localparam int TAP_92  = 92;
  localparam int TAP_171 = 171;
  localparam int TAP_162 = 162;
  localparam int TAP_177 = 177;
  localparam int TAP_175 = 175;
  localparam int TAP_176 = 176;
  localparam int TAP_264 = 264;
  localparam int TAP_243 = 243;
  localparam int TAP_288 = 288;
  localparam int TAP_286 = 286;
  localparam int TAP_287 = 287;
  localparam int TAP_69  = 69;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } fsm_state_t;

  // Layout from MSB down: s286..s288 = 1, s178..s285 = 0, s174..s177 = 0, IV, s81..s93 = 0, key.
  function automatic logic [STATE_W-1:0] load_state(input logic [KEY_W-1:0] key,
                                                   input logic [KEY_W-1:0] iv);
    return {3'b111, 108'd0, 4'd0, iv, 13'd0, key};
  endfunction

endpackage

// File: rtl/trivium_step.sv
// W chained Trivium rounds in one combinational block; z[j] is the output bit of round j.
module trivium_step
  import trivium_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [STATE_W-1:0] s,
  output logic [STATE_W-1:0] s_next,
  output logic [W-1:0]       z
);

  for (genvar j = 0; j < W; j++) begin : g_round
    logic [STATE_W-1:0] s_in;
    logic [STATE_W-1:0] s_out;
    logic t1, t2, t3;
    logic t1_fb, t2_fb, t3_fb;

    if (j == 0) begin : g_first
      assign s_in = s;
    end else begin : g_chain
      assign s_in = g_round[j-1].s_out;
    end

    assign t1 = s_in[TAP_66-1]  ^ s_in[TAP_93-1];
    assign t2 = s_in[TAP_162-1] ^ s_in[TAP_177-1];
    assign t3 = s_in[TAP_243-1] ^ s_in[TAP_288-1];
    assign z[j] = t1 ^ t2 ^ t3;

    assign t1_fb = t1 ^ (s_in[TAP_91-1]  & s_in[TAP_92-1])  ^ s_in[TAP_171-1];
    assign t2_fb = t2 ^ (s_in[TAP_175-1] & s_in[TAP_176-1]) ^ s_in[TAP_264-1];
    assign t3_fb = t3 ^ (s_in[TAP_286-1] & s_in[TAP_287-1]) ^ s_in[TAP_69-1];

    // Each of the three registers shifts up by one; the feedback enters at its lowest bit.
    assign s_out = {s_in[286:177], t2_fb, s_in[175:93], t1_fb, s_in[91:0], t3_fb};
  end

  assign s_next = g_round[W-1].s_out;

endmodule

// File: rtl/trivium_wide_keystream.sv
// Trivium keystream generator producing W bits per clock with start/stop control,
// valid/ready output handshake and a saturating accepted-word counter.
module trivium_wide_keystream
  import trivium_pkg::*;
#(
  parameter int W           = 8,
  parameter int INIT_ROUNDS = INIT_ROUNDS_DEF,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic [KEY_W-1:0] iv,
  input  logic             stop,
  output logic             busy,
  output logic             ks_valid,
  input  logic             ks_ready,
  output logic [W-1:0]     ks_data,
  output logic [CNT_W-1:0] ks_count
);

  localparam int WARM_STEPS = INIT_ROUNDS / W;
  localparam int WARM_W     = (WARM_STEPS > 1) ? $clog2(WARM_STEPS) : 1;
  localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(WARM_STEPS - 1);

  if (W < 1 || W > 64 || (INIT_ROUNDS % W) != 0) begin : g_param_check
    $error("trivium_wide_keystream: W must be 1..64 and divide INIT_ROUNDS");
  end

  fsm_state_t         state_q, state_d;
  logic [STATE_W-1:0] s_q, s_d;
  logic [STATE_W-1:0] s_step;
  logic [WARM_W-1:0]  warm_q, warm_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  trivium_step #(.W(W)) u_step (
    .s      (s_q),
    .s_next (s_step),
    .z      (ks_data)
  );

  // Handshake: a word transfers on any rising edge where ks_valid & ks_ready; while
  // ks_valid & !ks_ready the state (and so ks_data) and ks_count stay frozen.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    warm_d  = warm_q;
    cnt_d   = cnt_q;
    if (start) begin
      state_d = ST_WARMUP;
      s_d     = load_state(key, iv);
      warm_d  = WARM_LOAD;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_WARMUP: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else begin
            s_d = s_step;
            if (warm_q == '0) state_d = ST_RUN;
            else              warm_d  = warm_q - WARM_W'(1);
          end
        end
        ST_RUN: begin
          if (ks_ready) begin
            s_d = s_step;
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          end
          if (stop) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      warm_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      warm_q  <= warm_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q == ST_WARMUP);
  assign ks_valid = (state_q == ST_RUN);
  assign ks_count = cnt_q;

endmodule
